// File: rtl/draw_block_row_pkg.sv
// Shared constants, FSM encoding and width clamping for the block-row painter.
package draw_block_row_pkg;

   localparam int BLOCK_PX  = 4;
   localparam int SCREEN_W  = 160;
   localparam int SCREEN_H  = 120;
   localparam int MAX_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // A zero-width request still paints one block; oversize requests saturate.
   function automatic logic [3:0] clamp_width(input logic [3:0] width, input int max_w);
      if (width == 4'd0) begin
         return 4'd1;
      end else if (int'(width) > max_w) begin
         return 4'(max_w);
      end else begin
         return width;
      end
   endfunction

endpackage

// File: rtl/draw_block_row_if.sv
// Request/pixel bundle between a row requester and the painter.
interface draw_block_row_if;

   logic       start;
   logic [7:0] x_in;
   logic [6:0] y_in;
   logic [2:0] colour_in;
   logic [3:0] width_in;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       plot;
   logic       busy;
   logic       done;

   modport master (
      output start, x_in, y_in, colour_in, width_in,
      input  vga_x, vga_y, vga_colour, plot, busy, done
   );

   modport slave (
      input  start, x_in, y_in, colour_in, width_in,
      output vga_x, vga_y, vga_colour, plot, busy, done
   );

endinterface

// File: rtl/block_offset_counter.sv
// Raster offset generator: cx sweeps 0..limit-1, ry advances when cx wraps.
module block_offset_counter #(
   parameter int BLOCK_PX = 4,
   parameter int CX_W     = 6,
   parameter int RY_W     = 2
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            clear,
   input  logic            step,
   input  logic [CX_W-1:0] limit,
   output logic [CX_W-1:0] cx,
   output logic [RY_W-1:0] ry,
   output logic            last
);

   logic row_end;

   assign row_end = (cx == limit - CX_W'(1));
   assign last    = row_end && (ry == RY_W'(BLOCK_PX - 1));

   // Column offset is the inner loop; row offset wraps after the final block row.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cx <= '0;
         ry <= '0;
      end else if (clear) begin
         cx <= '0;
         ry <= '0;
      end else if (step) begin
         if (row_end) begin
            cx <= '0;
            ry <= last ? '0 : ry + RY_W'(1);
         end else begin
            cx <= cx + CX_W'(1);
         end
      end
   end

endmodule

// File: rtl/draw_block_row.sv
// Paints one row of square blocks into a VGA adapter, one pixel per cycle.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; request fields latched on accept
//   DRAW    | stepping the offset counter, one pixel presented per cycle
//   DONE    | single cycle after the last pixel; emits the done pulse
//
// All outputs are registered one cycle behind the state/counters, so the
// visible busy window spans the N pixels plus the done cycle.
module draw_block_row #(
   parameter int BLOCK_PX  = draw_block_row_pkg::BLOCK_PX,
   parameter int SCREEN_W  = draw_block_row_pkg::SCREEN_W,
   parameter int MAX_WIDTH = draw_block_row_pkg::MAX_WIDTH
) (
   input  logic                    clk,
   input  logic                    resetn,
   draw_block_row_if.slave         bus
);

   import draw_block_row_pkg::*;

   localparam int CX_W = $clog2(MAX_WIDTH * BLOCK_PX + 1);
   localparam int RY_W = (BLOCK_PX > 1) ? $clog2(BLOCK_PX) : 1;

   state_t state;
   state_t state_next;

   logic            latch;
   logic            clear;
   logic            step;
   logic            last;

   logic [7:0]      x_lat;
   logic [6:0]      y_lat;
   logic [2:0]      colour_lat;
   logic [3:0]      w_lat;

   logic [CX_W-1:0] limit;
   logic [CX_W-1:0] cx;
   logic [RY_W-1:0] ry;

   logic [8:0]      x_sum;
   logic [7:0]      y_sum;
   logic            on_screen;

   logic [7:0]      vga_x_q;
   logic [6:0]      vga_y_q;
   logic [2:0]      vga_colour_q;
   logic            plot_q;
   logic            busy_q;
   logic            done_q;

   assign limit = CX_W'(w_lat) * CX_W'(BLOCK_PX);

   // x is summed at 9 bits so a row running past x=255 is still seen as off-screen.
   assign x_sum     = {1'b0, x_lat} + 9'(cx);
   assign y_sum     = {1'b0, y_lat} + 8'(ry);
   assign on_screen = (x_sum < 9'(SCREEN_W)) && (y_sum < 8'(SCREEN_H));

   block_offset_counter #(
      .BLOCK_PX (BLOCK_PX),
      .CX_W     (CX_W),
      .RY_W     (RY_W)
   ) u_offset (
      .clk    (clk),
      .resetn (resetn),
      .clear  (clear),
      .step   (step),
      .limit  (limit),
      .cx     (cx),
      .ry     (ry),
      .last   (last)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and counter control; start is only honoured in IDLE.
   always_comb begin
      state_next = state;
      latch      = 1'b0;
      clear      = 1'b0;
      step       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               latch      = 1'b1;
               clear      = 1'b1;
               state_next = ST_DRAW;
            end
         end
         ST_DRAW: begin
            step = 1'b1;
            if (last) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Request capture; later input changes cannot disturb the row in progress.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         x_lat      <= '0;
         y_lat      <= '0;
         colour_lat <= '0;
         w_lat      <= '0;
      end else if (latch) begin
         x_lat      <= bus.x_in;
         y_lat      <= bus.y_in;
         colour_lat <= bus.colour_in;
         w_lat      <= clamp_width(bus.width_in, MAX_WIDTH);
      end
   end

   // Output stage: present the current pixel and the status flags one cycle later.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         plot_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         busy_q <= (state != ST_IDLE);
         done_q <= (state == ST_DONE);
         plot_q <= (state == ST_DRAW) && on_screen;
         if (state == ST_DRAW) begin
            vga_x_q      <= x_sum[7:0];
            vga_y_q      <= y_sum[6:0];
            vga_colour_q <= colour_lat;
         end
      end
   end

   assign bus.vga_x      = vga_x_q;
   assign bus.vga_y      = vga_y_q;
   assign bus.vga_colour = vga_colour_q;
   assign bus.plot       = plot_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule
